// File: rtl/ingress_cell_queue_if.sv
// Bundle between one input port's cell queue, the port receive logic and the output arbiter.
// master = receive logic + arbiter side, slave = the queue itself.
interface ingress_cell_queue_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_dst;
    logic [DATA_WIDTH-1:0] in_data;
    logic [ADDR_WIDTH-1:0] port_dst;
    logic                  grant;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CNT_W-1:0]      count;
    logic [15:0]           drop_cnt;

    modport master (
        output in_valid, in_dst, in_data, grant,
        input  in_ready, port_dst, out_valid, out_data, count, drop_cnt
    );

    modport slave (
        input  in_valid, in_dst, in_data, grant,
        output in_ready, port_dst, out_valid, out_data, count, drop_cnt
    );
endinterface

// File: rtl/ingress_cell_queue.sv
// Per-input cell FIFO: queues {dst, data} cells, requests with the head mask, pops one cell per grant.
// Zero-mask cells complete the handshake but are discarded and counted.
module ingress_cell_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ingress_cell_queue_if.slave  bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int CELL_W = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [CELL_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic              not_empty;
    logic              in_ready;
    logic              accept;
    logic              push;
    logic              drop;
    logic              pop;
    logic [CELL_W-1:0] head;

    // Ready comes from the registered count only, so a pop never frees a slot in the same cycle.
    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q != FULL);
    assign accept    = bus.in_valid && in_ready;
    assign push      = accept && (bus.in_dst != '0);
    assign drop      = accept && (bus.in_dst == '0);
    assign pop       = bus.grant && not_empty;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is never reset; an entry is only read once count says it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_dst, bus.in_data};
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.port_dst  = not_empty ? head[CELL_W-1 -: ADDR_WIDTH] : '0;
    assign bus.out_valid = pop;
    assign bus.out_data  = not_empty ? head[DATA_WIDTH-1:0] : '0;
    assign bus.count     = count_q;
    assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_ingress_cell_queue.sv
// Self-checking bench for ingress_cell_queue against a queue-based reference model.
module tb_ingress_cell_queue;
    logic clk = 1'b0;
    logic rst_n;

    ingress_cell_queue_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(8)) bus ();

    ingress_cell_queue #(.DATA_WIDTH(32), .DEPTH(8), .ADDR_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_asrt = 0;
    int          n_fail = 0;
    logic [35:0] mq[$];
    logic [31:0] obs_log[$];
    logic [15:0] m_drop = 16'd0;
    int          n_popped = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model mid-cycle, then advance the model.
    task automatic cycle(input logic v, input logic [3:0] d, input logic [31:0] x, input logic g);
        int          sz;
        logic        acc;
        logic        pp;
        logic [35:0] tmp;
        bus.in_valid = v;
        bus.in_dst   = d;
        bus.in_data  = x;
        bus.grant    = g;
        @(negedge clk);
        sz = mq.size();
        check("in_ready",  64'(bus.in_ready),  64'(sz != 8));
        check("count",     64'(bus.count),     64'(sz));
        check("port_dst",  64'(bus.port_dst),  (sz != 0) ? 64'(mq[0][35:32]) : 64'd0);
        check("out_valid", 64'(bus.out_valid), 64'(g && (sz != 0)));
        check("out_data",  64'(bus.out_data),  (sz != 0) ? 64'(mq[0][31:0]) : 64'd0);
        check("drop_cnt",  64'(bus.drop_cnt),  64'(m_drop));
        if (bus.out_valid) obs_log.push_back(bus.out_data);
        acc = v && (sz < 8);
        pp  = g && (sz != 0);
        if (pp) begin
            tmp = mq.pop_front();
            n_popped++;
        end
        if (acc) begin
            if (d != 4'd0) mq.push_back({d, x});
            else if (m_drop != 16'hFFFF) m_drop++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && mq.size() != 0; c++) cycle(1'b0, 4'd0, 32'd0, 1'b1);
        check("drain_empty", 64'(mq.size()), 64'd0);
    endtask

    initial begin
        int          next;
        int          base;
        logic        v;
        logic [3:0]  d;
        logic        g;
        logic [31:0] x;

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_dst   = '0;
        bus.in_data  = '0;
        bus.grant    = 1'b1;
        #2;
        check("rst_count",     64'(bus.count),     64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_port_dst",  64'(bus.port_dst),  64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_drop_cnt",  64'(bus.drop_cnt),  64'd0);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, 4'd0, 32'd0, 1'b1);

        // Basic flow with no bypass and a stable request across a stall
        cycle(1'b1, 4'b0010, 32'hA5A5_0001, 1'b0);
        repeat (5) begin
            cycle(1'b0, 4'd0, 32'd0, 1'b0);
            check("basic_port_dst", 64'(bus.port_dst), 64'h2);
        end
        cycle(1'b0, 4'd0, 32'd0, 1'b1);
        check("basic_out_data", 64'(obs_log[obs_log.size()-1]), 64'hA5A5_0001);
        cycle(1'b0, 4'd0, 32'd0, 1'b0);

        // Fill to full, then offer a 9th cell while popping
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'($urandom_range(1, 15)), $urandom, 1'b0);
        cycle(1'b1, 4'b0100, 32'hDEAD_BEEF, 1'b1);
        cycle(1'b0, 4'd0, 32'd0, 1'b0);
        check("full_count_after", 64'(bus.count), 64'd7);
        drain();

        // Ordering through pointer wrap with random stalls
        next = 0;
        base = obs_log.size();
        n_popped = 0;
        for (int c = 0; c < 600 && n_popped < 20; c++) begin
            v = (next < 20) && ($urandom_range(0, 3) != 0);
            g = ($urandom_range(0, 2) != 0);
            x = 32'(next);
            if (v && mq.size() < 8) next++;
            cycle(v, 4'b1001, x, g);
        end
        check("order_pops", 64'(n_popped), 64'd20);
        for (int k = 0; k < 20 && (base + k) < obs_log.size(); k++)
            check("order_data", 64'(obs_log[base+k]), 64'(k));

        // Zero-mask drops between two valid cells
        base = obs_log.size();
        cycle(1'b1, 4'b0001, 32'h1111_0000, 1'b0);
        repeat (3) cycle(1'b1, 4'd0, 32'hBAD0_0000, 1'b0);
        cycle(1'b1, 4'b1000, 32'h2222_0000, 1'b0);
        cycle(1'b0, 4'd0, 32'd0, 1'b0);
        check("zm_drop_cnt", 64'(bus.drop_cnt), 64'd3);
        check("zm_count",    64'(bus.count),    64'd2);
        drain();
        check("zm_out_n",   64'(obs_log.size() - base), 64'd2);
        check("zm_out_0",   64'(obs_log[base]),         64'h1111_0000);
        check("zm_out_1",   64'(obs_log[base+1]),       64'h2222_0000);

        // Simultaneous push and pop at count 1
        base = obs_log.size();
        cycle(1'b1, 4'b0011, 32'hCAFE_0001, 1'b0);
        cycle(1'b1, 4'b0110, 32'hCAFE_0002, 1'b1);
        check("pp_popped_old", 64'(obs_log[base]), 64'hCAFE_0001);
        cycle(1'b0, 4'd0, 32'd0, 1'b0);
        check("pp_count",    64'(bus.count),    64'd1);
        check("pp_port_dst", 64'(bus.port_dst), 64'h6);
        drain();

        // Random mixed traffic including zero masks
        for (int c = 0; c < 300; c++) begin
            v = ($urandom_range(0, 2) != 0);
            d = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            cycle(v, d, $urandom, ($urandom_range(0, 2) == 0));
        end
        drain();

        // Asynchronous reset mid-traffic with 3 cells stored
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0101, $urandom, 1'b0);
        bus.in_valid = 1'b0;
        bus.grant    = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("mrst_count",     64'(bus.count),     64'd0);
        check("mrst_port_dst",  64'(bus.port_dst),  64'd0);
        check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mrst_in_ready",  64'(bus.in_ready),  64'd1);
        check("mrst_drop_cnt",  64'(bus.drop_cnt),  64'd0);
        mq.delete();
        m_drop = 16'd0;
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, 4'd0, 32'd0, 1'b1);

        // Drop counter saturation: bulk drops up to FFFE, then three more checked
        bus.in_valid = 1'b1;
        bus.in_dst   = 4'd0;
        bus.grant    = 1'b0;
        repeat (16'hFFFE) @(posedge clk);
        #1;
        m_drop = 16'hFFFE;
        cycle(1'b0, 4'd0, 32'd0, 1'b0);
        check("sat_preload", 64'(bus.drop_cnt), 64'hFFFE);
        repeat (3) cycle(1'b1, 4'd0, $urandom, 1'b0);
        cycle(1'b0, 4'd0, 32'd0, 1'b0);
        check("sat_hold", 64'(bus.drop_cnt), 64'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/ingress_cell_queue.md
# ingress_cell_queue

Per-input-port cell buffer of the 4-port switch, one instance per input, sitting directly upstream of the output arbiter. It accepts single-word cells (destination mask plus payload) from the port receive logic, queues them in FIFO order, and presents the head cell's one-hot/multicast destination mask to the arbiter as that port's request. When the arbiter grants the port, the head cell is driven to the crossbar and popped. Each grant moves exactly one whole cell, so the arbiter's all-or-nothing grant maps to a single pop.

## Interface
- DATA_WIDTH, 32, payload bits per cell
- DEPTH, 8, cell slots; power of two, ≥2
- ADDR_WIDTH, from packet_pkg (4), destination mask width, one bit per output port

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  cell offered by the receive logic
- in_ready  output  1  queue can accept a cell this cycle
- in_dst  input  ADDR_WIDTH  destination mask of the offered cell; bit i selects output i
- in_data  input  DATA_WIDTH  payload of the offered cell
- port_dst  output  ADDR_WIDTH  request mask to the arbiter; head cell's mask, or 0 when empty
- grant  input  1  this port's grant_bus bit from the arbiter, same cycle
- out_valid  output  1  head cell transferring to the crossbar this cycle
- out_data  output  DATA_WIDTH  head cell payload
- count  output  $clog2(DEPTH+1)  cells currently stored
- drop_cnt  output  16  cells discarded for an all-zero mask; saturating

## Operation
- Storage: circular buffer of DEPTH entries, each holding {dst, data}.
  - Write pointer, read pointer and count are registered.
  - Pointers wrap from DEPTH-1 to 0.
- Accept condition: a cell is accepted when in_valid && in_ready.
- in_ready = (count != DEPTH). It is derived from the registered count only.
  - When full, no cell is accepted, even if a pop happens in the same cycle.
- Zero-mask drop: an accepted cell with in_dst == 0 is not written.
  - drop_cnt increments by 1 and saturates at 16'hFFFF.
  - The drop is still a handshake: in_ready governs it exactly like a normal accept.
- Request: port_dst = head.dst when count != 0; otherwise 0.
- Pop and output:
  - out_valid = grant && (count != 0).
  - out_data = head.data when count != 0; otherwise 0.
  - On a clock edge with out_valid = 1, the read pointer advances and the head is removed.
- grant while empty: ignored. No pop, out_valid = 0, no error.
- Simultaneous push and pop: both happen and count is unchanged.
  - Pushing into an empty queue gives no bypass. The new cell first appears on port_dst the next cycle.
- Multicast: a cell with several mask bits set is popped once, on the single grant. Replication to multiple outputs is the crossbar's job.
- port_dst remains stable while the head is not granted. The arbiter keeps the request pending across retries.

## Timing
- Reset (asynchronous, rst_n low) takes effect immediately. The following values hold until the first clock edge after deassertion:
  - pointers = 0, count = 0, drop_cnt = 0
  - in_ready = 1
  - port_dst = 0, out_valid = 0, out_data = 0
- Reset mid-operation: all stored cells are lost and no partial state is retained. Storage contents need no reset.
- Write latency: a cell accepted at edge N is visible on port_dst/out_data after edge N, i.e. in cycle N+1.
- Grant path: port_dst → arbiter → grant → out_valid is purely combinational within one cycle. There is no register between grant and out_valid.
- Pop latency: the next cell is presented in the cycle after a granted pop.
- Throughput: one accept and one pop per cycle sustained, i.e. one cell/cycle when grants are continuous.
- count, in_ready and drop_cnt update only on clock edges.

## Test plan
- Reset/idle: assert rst_n=0 mid-traffic with 3 cells stored → count=0, port_dst=0, out_valid=0, in_ready=1, drop_cnt=0 immediately; after release, grant=1 produces out_valid=0.
- Basic flow: push {dst=4'b0010, data=32'hA5A5_0001}, then wait → port_dst=4'b0010 the next cycle; holding grant=0 for 5 cycles keeps port_dst stable; grant=1 → out_valid=1 and out_data=32'hA5A5_0001 that cycle, count 1→0.
- Fill/full: push 8 cells with grant=0 → count=8, in_ready=0; offer a 9th with grant=1 in the same cycle → 9th not accepted, count=7; next cycle in_ready=1.
- Ordering/wrap: push and pop 20 cells (data 0..19, dst=4'b1001), randomly stalling grant → out_data sequence is exactly 0..19 and port_dst=4'b1001 whenever count≠0.
- Zero mask: push 3 cells with in_dst=0 between two valid cells → drop_cnt=3, count=2, only the two valid cells are ever output; preload drop_cnt to 16'hFFFE and drop 3 more → drop_cnt holds at 16'hFFFF.
- Simultaneous push/pop at count=1 with grant=1 → count stays 1, the popped cell is the old head, the new cell is presented the next cycle.
